inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DATA_W, 32, instruction word width.
REQ-002 Parameter ADDR_W, 32, instruction address width.
REQ-003 Parameter DEPTH, 4, queue entries; power of two, >= 2.
REQ-004 Parameter SKID, 1, entries reserved for in-flight fetches; 0 <= SKID < DEPTH.
REQ-005 Parameter NUM_WAYS, 2, number of parallel fetch ways in the core.
REQ-006 Parameter WAY_ID, 0, index of this way; 0 <= WAY_ID < NUM_WAYS.
REQ-007 Parameter PID_W, 2, program-order tag width; 2^PID_W >= NUM_WAYS.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 flush_i  input  1  jump/redirect; discard all queued and incoming entries.
REQ-011 in_valid_i  input  1  fetched instruction present.
REQ-012 in_ready_o  output  1  queue can accept.
REQ-013 in_inst_i  input  DATA_W  fetched instruction.
REQ-014 in_addr_i  input  ADDR_W  address of fetched instruction.
REQ-015 out_valid_o  output  1  head entry valid.
REQ-016 out_ready_i  input  1  decode stage accepts head.
REQ-017 out_inst_o  output  DATA_W  head instruction.
REQ-018 out_addr_o  output  ADDR_W  head address.
REQ-019 out_pid_o  output  PID_W  program-order tag of head.
REQ-020 count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-021 Push SHALL occur when in_valid_i && in_ready_o && !flush_i; entry {inst, addr} written at tail.
REQ-022 Pop SHALL occur when out_valid_o && out_ready_i && !flush_i; head advances.
REQ-023 in_ready_o SHALL equal (count_o < DEPTH - SKID), from registered state only; no dependence on out_ready_i.
REQ-024 out_valid_o SHALL equal (count_o != 0); first-word-fall-through, head data stable while out_valid_o && !out_ready_i.
REQ-025 Latency push to out_valid_o SHALL be exactly 1 cycle; no same-cycle bypass when empty.
REQ-026 Simultaneous push and pop SHALL leave count_o unchanged and both SHALL take effect.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty from MSB comparison; count_o = wptr - rptr.
REQ-028 out_pid_o SHALL start at WAY_ID and advance by NUM_WAYS, modulo 2^PID_W, on each pop.
REQ-029 flush_i SHALL, next cycle, give count_o=0, out_valid_o=0, out_pid_o=WAY_ID; push and pop in the flush cycle SHALL be discarded.
REQ-030 in_valid_i while in_ready_o=0 SHALL be ignored; no entry written, no state change.
REQ-031 out_inst_o/out_addr_o SHALL be don't-care when out_valid_o=0.

Reset
REQ-032 reset SHALL asynchronously force pointers to 0, count_o=0, out_valid_o=0, in_ready_o=1, out_pid_o=WAY_ID.
REQ-033 Storage array SHALL NOT require reset.
REQ-034 reset asserted mid-operation SHALL discard all entries; first push after deassertion SHALL pop with pid WAY_ID.

Structure
REQ-035 Package ifq_pkg SHALL hold default widths (DATA_W, ADDR_W, PID_W) and the entry typedef {addr, inst}.
REQ-036 One sub-module sync_fifo (parametric width/depth, flush port, count output) SHALL hold storage and pointers; pid counter and ready logic reside in inst_fetch_queue.

Verification
REQ-037 Reset, push addr 0x80000000 inst 0x00000013 -> next cycle out_valid_o=1, out_addr_o=0x80000000, out_pid_o=WAY_ID.
REQ-038 DEPTH=4, SKID=1, out_ready_i=0, push 3 -> in_ready_o=0 at count_o=3; 4th in_valid_i ignored, count_o stays 3.
REQ-039 Continuous push+pop, 10 entries, NUM_WAYS=2, WAY_ID=1, PID_W=2 -> pids 1,3,1,3,... in order, count_o constant 1, no loss.
REQ-040 count_o=3 with push and pop same cycle as flush_i -> next cycle count_o=0, out_valid_o=0, out_pid_o=WAY_ID.
REQ-041 Back-pressure: out_ready_i=0 for 5 cycles with head 0x80000004 -> out data and pid stable all 5 cycles.
REQ-042 reset asserted asynchronously mid-burst (count_o=2) -> outputs reach reset values before next clock edge.

Source files
------------

// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared defaults for the instruction fetch queue: widths of the instruction
// word, the instruction address and the program-order tag, plus the packed
// queue entry layout {addr, inst} at those default widths.
// No ports (package).
// ----------------------------------------------------------------------------
package ifq_pkg;

    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_ADDR_W = 32;
    localparam int IFQ_PID_W  = 2;

    // Address sits in the upper bits, instruction word in the lower bits.
    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] addr;
        logic [IFQ_DATA_W-1:0] inst;
    } ifq_entry_t;

endpackage : ifq_pkg

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with first-word-fall-through read port. Storage is
// a register array indexed by the low bits of one-bit-wider pointers; the extra
// pointer MSB distinguishes full from empty. A written word becomes visible on
// rd_data_o one cycle after the write (no same-cycle bypass).
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high; clears pointers
//   flush_i    in   clears pointers next cycle; write/read in that cycle dropped
//   wr_en_i    in   write wr_data_i at tail (ignored when full)
//   wr_data_i  in   WIDTH-bit write data
//   rd_en_i    in   advance head (ignored when empty)
//   rd_data_o  out  WIDTH-bit head data (undefined when empty)
//   count_o    out  occupied entries
//   empty_o    out  no entries
//   full_o     out  DEPTH entries
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] fill;
    logic             do_wr;
    logic             do_rd;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                     (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);

    assign do_wr = wr_en_i && !full_o  && !flush_i;
    assign do_rd = rd_en_i && !empty_o && !flush_i;

    // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy.
    assign fill    = wptr_q - rptr_q;
    assign count_o = CNT_W'(fill);

    assign rd_data_o = mem_q[rptr_q[IDX_W-1:0]];

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps always_comb from inferring a latch.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + PTR_W'(1);
            if (do_rd) rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their _d values from the same pre-edge snapshot, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; an entry is
    // only ever read after it has been written, and the pointers alone define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[IDX_W-1:0]] <= wr_data_i;
        end
    end

endmodule : sync_fifo

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
// Per-way instruction fetch queue between fetch and decode. Holds fetched
// {addr, inst} pairs in a sync_fifo and tags each popped head with a
// program-order id that starts at WAY_ID and steps by NUM_WAYS per pop, so
// interleaved ways reconstruct global order. SKID entries are kept free for
// fetches already in flight when in_ready_o drops.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high
//   flush_i      in   redirect: discard queued and incoming entries
//   in_valid_i   in   fetched instruction present
//   in_ready_o   out  queue can accept (count_o < DEPTH - SKID)
//   in_inst_i    in   fetched instruction word
//   in_addr_i    in   fetched instruction address
//   out_valid_o  out  head entry valid
//   out_ready_i  in   decode accepts head
//   out_inst_o   out  head instruction
//   out_addr_o   out  head address
//   out_pid_o    out  program-order tag of head
//   count_o      out  occupied entries
// ----------------------------------------------------------------------------
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DATA_W   = IFQ_DATA_W,
    parameter int ADDR_W   = IFQ_ADDR_W,
    parameter int DEPTH    = 4,
    parameter int SKID     = 1,
    parameter int NUM_WAYS = 2,
    parameter int WAY_ID   = 0,
    parameter int PID_W    = IFQ_PID_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_inst_i,
    input  logic [ADDR_W-1:0]            in_addr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_inst_o,
    output logic [ADDR_W-1:0]            out_addr_o,
    output logic [PID_W-1:0]             out_pid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - SKID);
    localparam logic [PID_W-1:0] PID_START   = PID_W'(WAY_ID);
    localparam logic [PID_W-1:0] PID_STEP    = PID_W'(NUM_WAYS);

    // Same layout as ifq_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [PID_W-1:0] pid_q, pid_d;

    // Ready looks only at registered occupancy, never at out_ready_i, so a pop
    // in the same cycle does not open a combinational path from decode to fetch.
    assign in_ready_o  = (fifo_count < READY_LIMIT);
    assign out_valid_o = !fifo_empty;

    assign push = in_valid_i  && in_ready_o  && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    assign wr_entry.addr = in_addr_i;
    assign wr_entry.inst = in_inst_i;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush_i),
        .wr_en_i   (push),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (rd_entry),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign out_inst_o = rd_entry.inst;
    assign out_addr_o = rd_entry.addr;
    assign count_o    = fifo_count;
    assign out_pid_o  = pid_q;

    // Tag wraps naturally modulo 2^PID_W.
    always_comb begin
        pid_d = pid_q;
        if (flush_i) begin
            pid_d = PID_START;
        end else if (pop) begin
            pid_d = pid_q + PID_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pid_q <= PID_START;
        end else begin
            pid_q <= pid_d;
        end
    end

    // Admission is gated by in_ready_o, which is always stricter than full.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Self-checking bench for inst_fetch_queue (DEPTH=4, SKID=1, NUM_WAYS=2,
// WAY_ID=1, PID_W=2). A queue of expected entries is filled when a push is
// driven and drained when the DUT hands the head to decode; every cycle the
// DUT head, occupancy, handshake and tag are compared against it. A table of
// vectors covers fill/back-pressure/drain, and hand sequences cover streaming,
// flush and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH    = 4;
    localparam int SKID     = 1;
    localparam int NUM_WAYS = 2;
    localparam int WAY_ID   = 1;
    localparam int PID_W    = 2;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] A = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [31:0]       in_inst_i = '0;
    logic [31:0]       in_addr_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_inst_o;
    logic [31:0]       out_addr_o;
    logic [PID_W-1:0]  out_pid_o;
    logic [CNT_W-1:0]  count_o;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (DEPTH),
        .SKID     (SKID),
        .NUM_WAYS (NUM_WAYS),
        .WAY_ID   (WAY_ID),
        .PID_W    (PID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_inst_i   (in_inst_i),
        .in_addr_i   (in_addr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_inst_o  (out_inst_o),
        .out_addr_o  (out_addr_o),
        .out_pid_o   (out_pid_o),
        .count_o     (count_o)
    );

    typedef struct {
        logic             flush;
        logic             in_valid;
        logic [31:0]      addr;
        logic [31:0]      inst;
        logic             out_ready;
        int               exp_count;   // occupancy after the edge
        logic             chk_head;    // compare head before the edge
        logic [31:0]      exp_addr;
        logic [PID_W-1:0] exp_pid;
    } vec_t;

    ifq_entry_t       sb[$];
    logic [PID_W-1:0] m_pid;
    int               n_tests = 0;
    int               n_fail  = 0;
    vec_t             vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] addr,
                                input logic [31:0] inst, input logic ordy, input int cnt,
                                input logic chk, input logic [31:0] ea, input logic [PID_W-1:0] ep);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.addr = addr; v.inst = inst; v.out_ready = ordy;
        v.exp_count = cnt; v.chk_head = chk; v.exp_addr = ea; v.exp_pid = ep;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [31:0] addr,
                         input logic [31:0] inst, input logic ordy);
        flush_i = fl; in_valid_i = iv; in_addr_i = addr; in_inst_i = inst; out_ready_i = ordy;
    endtask

    // Compare DUT outputs against the expected-entry queue (called before the edge).
    task automatic check_outputs(input string tag);
        check({tag, ".count"},    64'(count_o),     64'(sb.size()));
        check({tag, ".valid"},    64'(out_valid_o), 64'(sb.size() != 0));
        check({tag, ".ready"},    64'(in_ready_o),  64'(sb.size() < DEPTH - SKID));
        check({tag, ".pid"},      64'(out_pid_o),   64'(m_pid));
        if (sb.size() != 0) begin
            check({tag, ".addr"}, 64'(out_addr_o),  64'(sb[0].addr));
            check({tag, ".inst"}, 64'(out_inst_o),  64'(sb[0].inst));
        end
    endtask

    // Clock one edge and update the expected state from the driven inputs.
    task automatic tick();
        ifq_entry_t e;
        bit do_pop;
        bit do_push;
        bit fl;
        fl      = flush_i;
        do_pop  = !flush_i && out_ready_i && (sb.size() != 0);
        do_push = !flush_i && in_valid_i  && (sb.size() < DEPTH - SKID);
        e.addr  = in_addr_i;
        e.inst  = in_inst_i;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_pid = PID_W'(WAY_ID);
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                m_pid = m_pid + PID_W'(NUM_WAYS);
            end
            if (do_push) sb.push_back(e);
        end
    endtask

    task automatic step(input string tag, input logic fl, input logic iv, input logic [31:0] addr,
                        input logic [31:0] inst, input logic ordy);
        drive(fl, iv, addr, inst, ordy);
        #2;
        check_outputs(tag);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill, skid limit, back-pressure on head 0x80000004, drain.
        vecs[0]  = mk(0, 1, A + 32'h00, 32'h0000_0013, 0, 1, 0, '0,         '0);
        vecs[1]  = mk(0, 1, A + 32'h04, 32'h0010_0093, 1, 1, 1, A,          2'd1);
        vecs[2]  = mk(0, 1, A + 32'h08, 32'h0020_0113, 0, 2, 1, A + 32'h04, 2'd3);
        vecs[3]  = mk(0, 1, A + 32'h0C, 32'h0030_0193, 0, 3, 1, A + 32'h04, 2'd3);
        vecs[4]  = mk(0, 1, A + 32'h10, 32'h0040_0213, 0, 3, 1, A + 32'h04, 2'd3);
        vecs[5]  = mk(0, 0, '0,         '0,            0, 3, 1, A + 32'h04, 2'd3);
        vecs[6]  = mk(0, 0, '0,         '0,            0, 3, 1, A + 32'h04, 2'd3);
        vecs[7]  = mk(0, 0, '0,         '0,            0, 3, 1, A + 32'h04, 2'd3);
        vecs[8]  = mk(0, 0, '0,         '0,            0, 3, 1, A + 32'h04, 2'd3);
        vecs[9]  = mk(0, 0, '0,         '0,            1, 2, 1, A + 32'h04, 2'd3);
        vecs[10] = mk(0, 0, '0,         '0,            1, 1, 1, A + 32'h08, 2'd1);
        vecs[11] = mk(0, 0, '0,         '0,            1, 0, 1, A + 32'h0C, 2'd3);
        vecs[12] = mk(0, 0, '0,         '0,            0, 0, 0, '0,         '0);

        // Power-on reset.
        m_pid = PID_W'(WAY_ID);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.count", 64'(count_o),     64'd0);
        check("rst.valid", 64'(out_valid_o), 64'd0);
        check("rst.ready", 64'(in_ready_o),  64'd1);
        check("rst.pid",   64'(out_pid_o),   64'(WAY_ID));

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].addr, vecs[i].inst, vecs[i].out_ready);
            #2;
            check_outputs(tag);
            if (vecs[i].chk_head) begin
                check({tag, ".head_addr"}, 64'(out_addr_o), 64'(vecs[i].exp_addr));
                check({tag, ".head_pid"},  64'(out_pid_o),  64'(vecs[i].exp_pid));
            end
            tick();
            check({tag, ".count_after"}, 64'(count_o), 64'(vecs[i].exp_count));
        end

        // Streaming push+pop after a fresh reset: tags alternate 1,3,... and occupancy holds at 1.
        drive(0, 0, '0, '0, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        m_pid = PID_W'(WAY_ID);
        step("stream.first", 0, 1, A + 32'h200, 32'h0000_0513, 1);
        for (int k = 0; k < 10; k++) begin
            string tag;
            tag = $sformatf("stream%0d", k);
            drive(0, 1, A + 32'h204 + 32'(4 * k), 32'h0010_0513 + 32'(k << 20), 1);
            #2;
            check_outputs(tag);
            check({tag, ".pid_seq"}, 64'(out_pid_o), (k % 2 == 0) ? 64'd1 : 64'd3);
            tick();
            check({tag, ".count_hold"}, 64'(count_o), 64'd1);
        end
        step("stream.drain", 0, 0, '0, '0, 1);

        // Flush at count 3 with push and pop requested in the same cycle.
        step("fl.fill0", 0, 1, A + 32'h300, 32'h0000_0001, 0);
        step("fl.fill1", 0, 1, A + 32'h304, 32'h0000_0002, 0);
        step("fl.fill2", 0, 1, A + 32'h308, 32'h0000_0003, 0);
        check("fl.pre_count", 64'(count_o), 64'd3);
        step("fl.cycle", 1, 1, A + 32'h30C, 32'h0000_0004, 1);
        check("fl.count", 64'(count_o),     64'd0);
        check("fl.valid", 64'(out_valid_o), 64'd0);
        check("fl.pid",   64'(out_pid_o),   64'(WAY_ID));

        // Asynchronous reset mid-burst at count 2 with a non-initial tag.
        step("ar.p0", 0, 1, A + 32'h400, 32'h0000_0011, 0);
        step("ar.p1", 0, 1, A + 32'h404, 32'h0000_0022, 1);
        step("ar.p2", 0, 1, A + 32'h408, 32'h0000_0033, 0);
        check("ar.pre_count", 64'(count_o),   64'd2);
        check("ar.pre_pid",   64'(out_pid_o), 64'd3);
        drive(0, 0, '0, '0, 0);
        #2 reset = 1'b1;
        #1;
        check("ar.count", 64'(count_o),     64'd0);
        check("ar.valid", 64'(out_valid_o), 64'd0);
        check("ar.ready", 64'(in_ready_o),  64'd1);
        check("ar.pid",   64'(out_pid_o),   64'(WAY_ID));
        sb.delete();
        m_pid = PID_W'(WAY_ID);
        @(posedge clk);
        #1 reset = 1'b0;
        check_outputs("ar.post");
        step("ar.push", 0, 1, A + 32'h500, 32'h0000_0044, 0);
        drive(0, 0, '0, '0, 1);
        #2;
        check_outputs("ar.pop");
        check("ar.first_pid",  64'(out_pid_o),  64'(WAY_ID));
        check("ar.first_addr", 64'(out_addr_o), 64'(A + 32'h500));
        tick();
        check("ar.drained", 64'(count_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_queue
